// File: rtl/a5_pkg.sv
// a5_pkg: shared constants and types for the A5/1 keystream engine.
//   - register lengths, feedback tap masks, clocking-bit indices of R1..R3
//   - FSM state encoding
//   - max3 helper used to size the shared step counter
package a5_pkg;

    localparam int R1_LEN = 19;
    localparam int R2_LEN = 22;
    localparam int R3_LEN = 23;

    localparam logic [R1_LEN-1:0] R1_TAPS = 19'h7_2000;   // bits 13,16,17,18
    localparam logic [R2_LEN-1:0] R2_TAPS = 22'h30_0000;  // bits 20,21
    localparam logic [R3_LEN-1:0] R3_TAPS = 23'h70_0080;  // bits 7,20,21,22

    localparam int R1_CLK = 8;
    localparam int R2_CLK = 10;
    localparam int R3_CLK = 10;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_KEY,
        REPLAY,
        LOAD_FRAME,
        MIX,
        RUN
    } a5_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/a5_lfsr.sv
// a5_lfsr: one A5/1 shift register (Fibonacci, shifts toward the MSB).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   clear_i         zero the register (takes priority over shift_i)
//   shift_i         perform one shift this cycle
//   inject_i        bit XORed into bit 0 after the feedback (load steps only)
//   clk_bit_o       current clocking bit, used by the majority vote
//   msb_o           MSB as it will be after this cycle's update, so the
//                   output bit can be sampled on the same edge as the step
module a5_lfsr #(
    parameter int             LEN      = 19,
    parameter logic [LEN-1:0] TAP_MASK = '0,
    parameter int             CLK_BIT  = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic shift_i,
    input  logic inject_i,
    output logic clk_bit_o,
    output logic msb_o
);

    logic [LEN-1:0] r_q, r_d;

    always_comb begin
        r_d = r_q;
        if (clear_i) begin
            r_d = '0;
        end else if (shift_i) begin
            r_d = {r_q[LEN-2:0], ^(r_q & TAP_MASK)} ^ LEN'(inject_i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else begin
            r_q <= r_d;
        end
    end

    assign clk_bit_o = r_q[CLK_BIT];
    assign msb_o     = r_d[LEN-1];

endmodule

// File: rtl/a5_stream_engine.sv
// a5_stream_engine: A5/1 keystream generator with key store and packed
// valid/ready keystream output.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   startloading   pulse: restart keying (clears LFSRs, counter, packer, ks_valid)
//   rekey          with startloading: replay the stored key instead of taking it
//   keybit         serial key/frame bit, LSB first, qualified by key_valid
//   key_valid      keybit qualifier during LOAD_KEY / LOAD_FRAME
//   ks_ready       downstream accepts ks_word
//   ks_word        OUT_W keystream bits, first generated bit in the MSB
//   ks_valid       ks_word holds an unconsumed word
//   doneloading    high in RUN
//   busy           high in LOAD_KEY, REPLAY, LOAD_FRAME, MIX
//
// state      | meaning
// IDLE       | waiting for startloading
// LOAD_KEY   | one load step per accepted keybit, key also captured
// REPLAY     | one load step per cycle from the rotating key store
// LOAD_FRAME | one load step per accepted frame bit
// MIX        | majority steps, output discarded
// RUN        | majority step + output bit into packer, word handshake
module a5_stream_engine
    import a5_pkg::*;
#(
    parameter int KEY_LEN   = 64,
    parameter int FRAME_LEN = 22,
    parameter int MIX_STEPS = 100,
    parameter int OUT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             startloading,
    input  logic             rekey,
    input  logic             keybit,
    input  logic             key_valid,
    input  logic             ks_ready,
    output logic [OUT_W-1:0] ks_word,
    output logic             ks_valid,
    output logic             doneloading,
    output logic             busy
);

    localparam int CNT_W  = $clog2(max3(KEY_LEN, FRAME_LEN, MIX_STEPS) + 1);
    localparam int PCNT_W = $clog2(OUT_W + 1);

    a5_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [KEY_LEN-1:0] key_q, key_d;
    logic [OUT_W-1:0]  pack_q, pack_d;
    logic [PCNT_W-1:0] pcnt_q, pcnt_d;
    logic [OUT_W-1:0]  ks_word_q, ks_word_d;
    logic              ks_valid_q, ks_valid_d;

    logic lfsr_clear, load_step, maj_step, inject;
    logic c1, c2, c3, m1, m2, m3, maj, sh1, sh2, sh3, out_bit;
    logic pack_full, xfer, run_step;

    assign maj     = (c1 & c2) | (c1 & c3) | (c2 & c3);
    assign sh1     = load_step | (maj_step & (c1 == maj));
    assign sh2     = load_step | (maj_step & (c2 == maj));
    assign sh3     = load_step | (maj_step & (c3 == maj));
    assign out_bit = m1 ^ m2 ^ m3;

    // A full packer moves into ks_word once the current word is gone or is
    // being taken this edge; the same edge may already start the next word.
    assign pack_full = (pcnt_q == PCNT_W'(OUT_W));
    assign xfer      = pack_full && (!ks_valid_q || ks_ready);
    assign run_step  = !pack_full || xfer;

    a5_lfsr #(.LEN(R1_LEN), .TAP_MASK(R1_TAPS), .CLK_BIT(R1_CLK)) u_r1 (
        .clk(clk), .rst(rst), .clear_i(lfsr_clear), .shift_i(sh1),
        .inject_i(inject), .clk_bit_o(c1), .msb_o(m1)
    );
    a5_lfsr #(.LEN(R2_LEN), .TAP_MASK(R2_TAPS), .CLK_BIT(R2_CLK)) u_r2 (
        .clk(clk), .rst(rst), .clear_i(lfsr_clear), .shift_i(sh2),
        .inject_i(inject), .clk_bit_o(c2), .msb_o(m2)
    );
    a5_lfsr #(.LEN(R3_LEN), .TAP_MASK(R3_TAPS), .CLK_BIT(R3_CLK)) u_r3 (
        .clk(clk), .rst(rst), .clear_i(lfsr_clear), .shift_i(sh3),
        .inject_i(inject), .clk_bit_o(c3), .msb_o(m3)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        key_d      = key_q;
        lfsr_clear = 1'b0;
        load_step  = 1'b0;
        maj_step   = 1'b0;
        inject     = 1'b0;
        case (state_q)
            LOAD_KEY: begin
                if (key_valid) begin
                    load_step = 1'b1;
                    inject    = keybit;
                    key_d     = {keybit, key_q[KEY_LEN-1:1]};
                    if (cnt_q == '0) begin
                        state_d = LOAD_FRAME;
                        cnt_d   = CNT_W'(FRAME_LEN - 1);
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            REPLAY: begin
                // Rotation: after KEY_LEN steps the store is back where it began.
                load_step = 1'b1;
                inject    = key_q[0];
                key_d     = {key_q[0], key_q[KEY_LEN-1:1]};
                if (cnt_q == '0) begin
                    state_d = LOAD_FRAME;
                    cnt_d   = CNT_W'(FRAME_LEN - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            LOAD_FRAME: begin
                if (key_valid) begin
                    load_step = 1'b1;
                    inject    = keybit;
                    if (cnt_q == '0) begin
                        state_d = MIX;
                        cnt_d   = CNT_W'(MIX_STEPS - 1);
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            MIX: begin
                maj_step = 1'b1;
                if (cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RUN: begin
                maj_step = run_step;
            end
            default: ;
        endcase
        if (startloading) begin
            state_d    = rekey ? REPLAY : LOAD_KEY;
            cnt_d      = CNT_W'(KEY_LEN - 1);
            key_d      = key_q;
            lfsr_clear = 1'b1;
            load_step  = 1'b0;
            maj_step   = 1'b0;
            inject     = 1'b0;
        end
    end

    always_comb begin
        pack_d     = pack_q;
        pcnt_d     = pcnt_q;
        ks_word_d  = ks_word_q;
        ks_valid_d = ks_valid_q;
        if (startloading) begin
            pack_d     = '0;
            pcnt_d     = '0;
            ks_valid_d = 1'b0;
        end else if (state_q == RUN) begin
            if (xfer) begin
                ks_word_d  = pack_q;
                ks_valid_d = 1'b1;
            end else if (ks_ready) begin
                ks_valid_d = 1'b0;
            end
            if (run_step) begin
                pack_d = ((xfer ? '0 : pack_q) << 1) | OUT_W'(out_bit);
                pcnt_d = (xfer ? '0 : pcnt_q) + PCNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            key_q      <= '0;
            pack_q     <= '0;
            pcnt_q     <= '0;
            ks_word_q  <= '0;
            ks_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            key_q      <= key_d;
            pack_q     <= pack_d;
            pcnt_q     <= pcnt_d;
            ks_word_q  <= ks_word_d;
            ks_valid_q <= ks_valid_d;
        end
    end

    assign ks_word     = ks_word_q;
    assign ks_valid    = ks_valid_q;
    assign doneloading = (state_q == RUN);
    assign busy        = (state_q == LOAD_KEY) || (state_q == REPLAY) ||
                         (state_q == LOAD_FRAME) || (state_q == MIX);

endmodule
